// File: rtl/rl_pkg.sv
// Shared RL definitions: state encodings and bus widths used by the DMA engine and the RL11
// register block.
package rl_pkg;

    localparam int unsigned RL_WORD_W = 16;
    localparam int unsigned RL_ADDR_W = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    typedef logic [RL_WORD_W-1:0] rl_word_t;
    typedef logic [RL_ADDR_W-1:0] rl_addr_t;

    function automatic rl_addr_t rl_word_align(input rl_addr_t addr);
        return addr & ~rl_addr_t'(1);
    endfunction

endpackage

// File: rtl/rl_dma_engine_if.sv
// Command, stream and rlmem bridge signals of the RL DMA engine. The master modport is the
// engine's view; the slave modport is the view of everything around it.
interface rl_dma_engine_if;
    import rl_pkg::*;

    logic     cmdvalid;
    logic     cmdready;
    logic     cmdwr;
    rl_addr_t cmdaddr;
    rl_word_t cmdcount;
    logic     abort;

    logic     outvalid;
    logic     outready;
    rl_word_t outdata;
    logic     invalid;
    logic     inready;
    rl_word_t indata;

    logic     done;
    logic     doneabort;
    rl_word_t donecount;

    logic     rlmemreq;
    logic     rlmemwr;
    rl_addr_t rlmemaddr;
    rl_word_t rlmemwdata;
    logic     rlmemack;
    rl_word_t rlmemrdata;

    modport master (
        input  cmdvalid, cmdwr, cmdaddr, cmdcount, abort,
        input  outready, invalid, indata, rlmemack, rlmemrdata,
        output cmdready, outvalid, outdata, inready, done, doneabort, donecount,
        output rlmemreq, rlmemwr, rlmemaddr, rlmemwdata
    );

    modport slave (
        output cmdvalid, cmdwr, cmdaddr, cmdcount, abort,
        output outready, invalid, indata, rlmemack, rlmemrdata,
        input  cmdready, outvalid, outdata, inready, done, doneabort, donecount,
        input  rlmemreq, rlmemwr, rlmemaddr, rlmemwdata
    );

endinterface

// File: rtl/rl_wordfifo.sv
// Synchronous word FIFO for read prefetch: registered occupancy count and a flush that
// empties it in one cycle.
module rl_wordfifo
    import rl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  rl_word_t               i_data,
    input  logic                   i_pop,
    output rl_word_t               o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    rl_word_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/rl_dma_engine.sv
// RL disk DMA engine: turns one transfer command into single-word requests on the AXI bridge
// rlmem port, streaming read words out through a prefetch FIFO and write words in directly.
module rl_dma_engine
    import rl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rstn,
    rl_dma_engine_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [2:0]       r_state, w_state_nxt;
    rl_addr_t         r_addr, w_addr_nxt;
    rl_word_t         r_remain, w_remain_nxt;
    rl_word_t         r_acked, w_acked_nxt;
    rl_word_t         r_wdata, w_wdata_nxt;
    logic             r_wr, w_wr_nxt;
    logic             r_abort, w_abort_nxt;
    logic             r_doneabort, w_doneabort_nxt;
    logic             r_req, w_req_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_inready;
    logic             w_fifo_valid;
    rl_word_t         w_fifo_data;
    logic [CNT_W-1:0] w_fifo_count;

    rl_wordfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (bus.rlmemrdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign w_pop = w_fifo_valid && bus.outready;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remain_nxt    = r_remain;
        w_acked_nxt     = r_acked;
        w_wdata_nxt     = r_wdata;
        w_wr_nxt        = r_wr;
        w_abort_nxt     = r_abort;
        w_doneabort_nxt = r_doneabort;
        w_req_nxt       = 1'b0;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        w_inready       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cmdvalid) begin
                    w_addr_nxt      = rl_word_align(bus.cmdaddr);
                    w_remain_nxt    = bus.cmdcount;
                    w_acked_nxt     = '0;
                    w_wr_nxt        = bus.cmdwr;
                    w_abort_nxt     = 1'b0;
                    w_doneabort_nxt = 1'b0;
                    w_state_nxt     = (bus.cmdcount == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    w_flush         = 1'b1;
                    w_doneabort_nxt = 1'b1;
                    w_state_nxt     = FINISH;
                end else if (r_wr) begin
                    w_inready = 1'b1;
                    if (bus.invalid) begin
                        w_wdata_nxt = bus.indata;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else if (w_fifo_count < FIFO_FULL) begin
                    // Nothing is outstanding here, so occupancy alone bounds the prefetch.
                    w_req_nxt   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.rlmemack) begin
                    w_addr_nxt   = r_addr + rl_addr_t'(2);
                    w_remain_nxt = r_remain - 1'b1;
                    w_acked_nxt  = r_acked + 1'b1;
                    // An abort arriving with the final ack does not spoil the completion.
                    if ((r_remain == rl_word_t'(1)) && !r_abort) begin
                        w_push      = !r_wr;
                        w_state_nxt = r_wr ? FINISH : DRAIN;
                    end else if (r_abort || bus.abort) begin
                        w_flush         = 1'b1;
                        w_doneabort_nxt = 1'b1;
                        w_state_nxt     = FINISH;
                    end else begin
                        w_push      = !r_wr;
                        w_state_nxt = ISSUE;
                    end
                end else if (bus.abort) begin
                    w_abort_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (!w_fifo_valid) w_state_nxt = FINISH;
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_acked     <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_abort     <= 1'b0;
            r_doneabort <= 1'b0;
            r_req       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remain    <= w_remain_nxt;
            r_acked     <= w_acked_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wr        <= w_wr_nxt;
            r_abort     <= w_abort_nxt;
            r_doneabort <= w_doneabort_nxt;
            r_req       <= w_req_nxt;
        end
    end

    assign bus.cmdready   = (r_state == IDLE);
    assign bus.outvalid   = w_fifo_valid;
    assign bus.outdata    = w_fifo_data;
    assign bus.inready    = w_inready;
    assign bus.done       = (r_state == FINISH);
    assign bus.doneabort  = r_doneabort;
    assign bus.donecount  = r_acked;
    assign bus.rlmemreq   = r_req;
    assign bus.rlmemwr    = r_wr;
    assign bus.rlmemaddr  = r_addr;
    assign bus.rlmemwdata = r_wdata;

endmodule
